// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter.
// Holds the response-state encoding, the streak counter width and a saturating increment.
package mem_port_arbiter_pkg;

  localparam int DEFAULT_MAX_STREAK = 4;
  localparam int STREAK_W           = 4;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_INST = 2'd1,
    RESP_DATA = 2'd2
  } resp_state_e;

  function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] v,
                                                 input logic [STREAK_W-1:0] lim);
    return (v >= lim) ? lim : v + STREAK_W'(1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and SRAM signals of the shared memory port.
// The master modport is the requester/SRAM side; the slave modport is the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [31:0]       inst_rdata;
  logic              inst_cancel;

  logic              data_req;
  logic [3:0]        data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [31:0]       data_rdata;

  logic              sram_en;
  logic [3:0]        sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;

  modport master (
    output inst_req, inst_addr, inst_cancel,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_we, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata,
    output sram_rdata
  );

  modport slave (
    input  inst_req, inst_addr, inst_cancel,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_we, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata,
    input  sram_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported SRAM between fetch and load/store, data-first with a fetch streak limit.
// Grants are combinational; read data returns to its owner exactly one cycle after the grant.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_STREAK = DEFAULT_MAX_STREAK,
  parameter int ADDR_W     = 32
) (
  input logic               clk,
  input logic               resetn,
  mem_port_arbiter_if.slave bus
);

  logic                force_inst;
  logic                grant_inst;
  logic                grant_data;
  logic [ADDR_W-1:0]   sram_addr_d;
  logic [31:0]         sram_wdata_d;
  logic [STREAK_W-1:0] streak_d, streak_q;
  resp_state_e         resp_d, resp_q;

  // Grants are gated by resetn so every output reads idle while reset is held.
  always_comb begin
    force_inst = bus.inst_req && (streak_q == STREAK_W'(MAX_STREAK));
    grant_inst = resetn && bus.inst_req && (!bus.data_req || force_inst);
    grant_data = resetn && bus.data_req && !grant_inst;

    sram_addr_d  = '0;
    sram_wdata_d = '0;
    if (grant_inst) begin
      sram_addr_d = bus.inst_addr;
    end else if (grant_data) begin
      sram_addr_d  = bus.data_addr;
      sram_wdata_d = bus.data_wdata;
    end

    streak_d = streak_q;
    if (grant_data && bus.inst_req) begin
      streak_d = sat_inc(streak_q, STREAK_W'(MAX_STREAK));
    end else if (grant_inst || !bus.inst_req) begin
      streak_d = '0;
    end

    // A fetch cancelled in its own grant cycle still reads the SRAM but never answers.
    resp_d = RESP_NONE;
    if (grant_inst && !bus.inst_cancel) begin
      resp_d = RESP_INST;
    end else if (grant_data) begin
      resp_d = RESP_DATA;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_q   <= RESP_NONE;
      streak_q <= '0;
    end else begin
      resp_q   <= resp_d;
      streak_q <= streak_d;
    end
  end

  assign bus.inst_addr_ok = grant_inst;
  assign bus.data_addr_ok = grant_data;

  assign bus.sram_en    = grant_inst || grant_data;
  assign bus.sram_we    = grant_data ? bus.data_we : 4'b0000;
  assign bus.sram_addr  = sram_addr_d;
  assign bus.sram_wdata = sram_wdata_d;

  assign bus.inst_data_ok = (resp_q == RESP_INST) && !bus.inst_cancel;
  assign bus.data_data_ok = (resp_q == RESP_DATA);
  assign bus.inst_rdata   = bus.inst_data_ok ? bus.sram_rdata : 32'h0;
  assign bus.data_rdata   = bus.data_data_ok ? bus.sram_rdata : 32'h0;

endmodule
